emsensor_array: RTL and testbench

Parametrised successor of the single-channel EM-sensor coprocessor. Monitors `NCH` independent EM glitch-sensor event lines and counts events per channel over a programmable observation window. A channel whose count reaches a programmable threshold raises a sticky alarm. The block sits on the coprocessor APB bus next to the other peripherals, exposes status, mask and configuration registers, and drives a combined alarm line to the SoC.

---
 rtl/emsensor_array_if.sv | 20 ++
 rtl/emsensor_array.sv | 137 +++++++++++++
 tb/tb_emsensor_array.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/emsensor_array_if.sv
// APB-style register bus between the coprocessor and emsensor_array.
// Master drives the request; slave returns combinational read data.
interface emsensor_array_if;
    logic [7:0]  vpsel;
    logic        vpenable;
    logic [31:0] vpaddr;
    logic        vpwrite;
    logic [31:0] vpwdata;
    logic [31:0] vprdata;

    modport master (
        output vpsel, vpenable, vpaddr, vpwrite, vpwdata,
        input  vprdata
    );

    modport slave (
        input  vpsel, vpenable, vpaddr, vpwrite, vpwdata,
        output vprdata
    );
endinterface

// File: rtl/emsensor_array.sv
// NCH-channel EM glitch-sensor event counter with windowed thresholds and sticky alarms.
// Optional interrupt output and IRQEN register are compiled in with EMSENSOR_IRQ_EN.
module emsensor_array #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CNTW     = 8,
    parameter int unsigned WINW     = 16,
    parameter int unsigned PSEL_IDX = 0
) (
    input  logic                vclk,
    input  logic                vrst,
    emsensor_array_if.slave     bus,
    input  logic [NCH-1:0]      sensor_evt,
    output logic                alarm
`ifdef EMSENSOR_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam logic [CNTW-1:0] CntMax = '1;

    logic                r_enable;
    logic [NCH-1:0]      r_status;
    logic [NCH-1:0]      r_mask;
    logic [WINW-1:0]     r_window;
    logic [CNTW-1:0]     r_thresh;
    logic [WINW-1:0]     r_timer;
    logic [CNTW-1:0]     r_cnt [NCH];

    logic                w_wr;
    logic [9:0]          w_idx;
    logic                w_win_end;
    logic                w_wr_window;
    logic                w_refresh;
    logic [NCH-1:0]      w_w1c;
    logic [NCH-1:0]      w_clr;
    logic [NCH-1:0]      w_hit;
    logic [31:0]         w_rdata;

    assign w_wr        = bus.vpsel[PSEL_IDX] & bus.vpenable & bus.vpwrite;
    assign w_idx       = bus.vpaddr[11:2];
    assign w_win_end   = r_enable && (r_timer == r_window);
    assign w_wr_window = w_wr && (w_idx == 10'd3);
    assign w_refresh   = w_wr && (w_idx == 10'd0) && bus.vpwdata[0];
    assign w_w1c       = (w_wr && (w_idx == 10'd1)) ? bus.vpwdata[NCH-1:0] : '0;
    assign w_clr       = (w_refresh ? {NCH{1'b1}} : {NCH{1'b0}}) | w_w1c;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNTW:0] w_sum;

        // One bit wider so a saturated count plus a last-cycle event still compares correctly.
        assign w_sum    = {1'b0, r_cnt[i]} + {{CNTW{1'b0}}, sensor_evt[i] & r_enable};
        assign w_hit[i] = w_win_end && (w_sum >= {1'b0, r_thresh});

        always_ff @(posedge vclk) begin
            if (vrst) begin
                r_cnt[i] <= '0;
            end else if (!r_enable || w_wr_window || w_win_end) begin
                r_cnt[i] <= '0;
            end else if (sensor_evt[i] && (r_cnt[i] != CntMax)) begin
                r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge vclk) begin
        if (vrst) begin
            r_timer <= '0;
        end else if (!r_enable || w_wr_window || w_win_end) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Window-end hits are ORed after clearing so they win over refresh/W1C.
    always_ff @(posedge vclk) begin
        if (vrst) begin
            r_enable <= 1'b1;
            r_status <= '0;
            r_mask   <= '0;
            r_window <= WINW'(255);
            r_thresh <= CNTW'(1);
        end else begin
            r_status <= (r_status & ~w_clr) | w_hit;
            if (w_wr) begin
                case (w_idx)
                    10'd0:   r_enable <= bus.vpwdata[1];
                    10'd2:   r_mask   <= bus.vpwdata[NCH-1:0];
                    10'd3:   r_window <= bus.vpwdata[WINW-1:0];
                    10'd4:   r_thresh <= bus.vpwdata[CNTW-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign alarm = |(r_status & ~r_mask);

`ifdef EMSENSOR_IRQ_EN
    logic r_irqen;
    logic r_irq;

    always_ff @(posedge vclk) begin
        if (vrst) begin
            r_irqen <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wr && (w_idx == 10'd6)) begin
                r_irqen <= bus.vpwdata[0];
            end
            r_irq <= alarm & r_irqen;
        end
    end

    assign irq = r_irq;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            10'd0:   w_rdata[1]        = r_enable;
            10'd1:   w_rdata[NCH-1:0]  = r_status;
            10'd2:   w_rdata[NCH-1:0]  = r_mask;
            10'd3:   w_rdata[WINW-1:0] = r_window;
            10'd4:   w_rdata[CNTW-1:0] = r_thresh;
            10'd5:   w_rdata           = {16'h0E5A, 8'(NCH), 8'(CNTW)};
`ifdef EMSENSOR_IRQ_EN
            10'd6:   w_rdata[0]        = r_irqen;
`endif
            default: w_rdata = '0;
        endcase
    end

    assign bus.vprdata = w_rdata;

endmodule

// File: tb/tb_emsensor_array.sv
// Directed bench for emsensor_array: register reads go through an expected-value queue.
// Inputs change on the falling edge; outputs are sampled just after it.
module tb_emsensor_array;

    logic       vclk = 1'b0;
    logic       vrst;
    logic [3:0] sensor_evt;
    logic       alarm;
`ifdef EMSENSOR_IRQ_EN
    logic       irq;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    emsensor_array_if bus ();

    emsensor_array #(
        .NCH(4), .CNTW(8), .WINW(16), .PSEL_IDX(0)
    ) dut (
        .vclk       (vclk),
        .vrst       (vrst),
        .bus        (bus.slave),
        .sensor_evt (sensor_evt),
        .alarm      (alarm)
`ifdef EMSENSOR_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 vclk = ~vclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge vclk);
    endtask

    // One-cycle write strobe; takes effect on the next rising edge, returns after it.
    task automatic wr(input int idx, input logic [31:0] data, input logic [7:0] sel = 8'h01);
        bus.vpsel    = sel;
        bus.vpenable = 1'b1;
        bus.vpwrite  = 1'b1;
        bus.vpaddr   = 32'(idx) << 2;
        bus.vpwdata  = data;
        @(negedge vclk);
        bus.vpsel    = 8'h00;
        bus.vpenable = 1'b0;
        bus.vpwrite  = 1'b0;
    endtask

    task automatic rd(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        bus.vpaddr = 32'(idx) << 2;
        #1;
        e = exp_q.pop_front();
        chk(tag, bus.vprdata, e);
    endtask

    task automatic pulse(input int ch, input int n);
        sensor_evt[ch] = 1'b1;
        cycles(n);
        sensor_evt[ch] = 1'b0;
    endtask

    initial begin
        vrst         = 1'b1;
        sensor_evt   = '0;
        bus.vpsel    = 8'h00;
        bus.vpenable = 1'b0;
        bus.vpwrite  = 1'b0;
        bus.vpaddr   = '0;
        bus.vpwdata  = '0;
        cycles(3);
        vrst = 1'b0;

        rd("rst_ctrl", 0, 32'd2);
        rd("rst_status", 1, 32'd0);
        rd("rst_mask", 2, 32'd0);
        rd("rst_window", 3, 32'd255);
        rd("rst_thresh", 4, 32'd1);
        rd("rst_info", 5, 32'h0E5A0408);
        rd("unmapped", 9, 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);

        wr(2, 32'hF, 8'h02);
        rd("unselected_write", 2, 32'd0);

        // Threshold crossing: window 0..9 starts right after the WINDOW write edge.
        wr(4, 32'd3);
        wr(3, 32'd9);
        rd("window_rb", 3, 32'd9);
        pulse(2, 3);
        cycles(6);
        rd("pre_end_status", 1, 32'd0);
        cycles(1);
        rd("cross_status", 1, 32'h4);
        chk("cross_alarm", 32'(alarm), 32'd1);

        wr(1, 32'h4);
        rd("w1c_status", 1, 32'd0);
        chk("w1c_alarm", 32'(alarm), 32'd0);
        pulse(2, 2);
        cycles(7);
        rd("below_thresh", 1, 32'd0);

        wr(2, 32'h4);
        wr(3, 32'd9);
        pulse(2, 3);
        cycles(7);
        rd("mask_status", 1, 32'h4);
        chk("mask_alarm", 32'(alarm), 32'd0);

        // Refresh lands on the window-end edge: ch0 hit survives, masked ch2 is cleared.
        wr(3, 32'd9);
        pulse(0, 3);
        cycles(6);
        wr(0, 32'h3);
        rd("prio_status", 1, 32'h1);
        chk("prio_alarm", 32'(alarm), 32'd1);
        rd("refresh_reads0", 0, 32'd2);

        wr(0, 32'h0);
        wr(1, 32'hF);
        pulse(1, 20);
        cycles(30);
        rd("disabled_status", 1, 32'd0);
        chk("disabled_alarm", 32'(alarm), 32'd0);
        wr(0, 32'h2);

        // Saturation: 600 events must not wrap past the 255 threshold.
        wr(4, 32'd255);
        wr(3, 32'd999);
        pulse(3, 600);
        cycles(399);
        rd("sat_pre_end", 1, 32'd0);
        cycles(1);
        rd("sat_status", 1, 32'h8);
        chk("sat_alarm", 32'(alarm), 32'd1);

        wr(1, 32'hF);
        wr(4, 32'd0);
        wr(3, 32'd9);
        cycles(10);
        rd("thresh0_status", 1, 32'hF);

`ifdef EMSENSOR_IRQ_EN
        wr(6, 32'd1);
        rd("irqen_rb", 6, 32'd1);
        wr(4, 32'd1);
        wr(0, 32'h3);
        cycles(1);
        chk("irq_cleared", 32'(irq), 32'd0);
        wr(3, 32'd9);
        pulse(0, 1);
        cycles(9);
        chk("irq_alarm", 32'(alarm), 32'd1);
        chk("irq_lag", 32'(irq), 32'd0);
        cycles(1);
        chk("irq_high", 32'(irq), 32'd1);
        wr(0, 32'h3);
        chk("irq_hold", 32'(irq), 32'd1);
        cycles(1);
        chk("irq_drop", 32'(irq), 32'd0);
`else
        wr(6, 32'd1);
        rd("idx6_absent", 6, 32'd0);
`endif

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
